mem_fb_tracker: RTL and testbench
=================================

// Module: mem_fb_tracker
// PURPOSE
// - Scoreboard-side receiver of memory-unit feedback; tracks each in-flight LW/SW per (warp, scoreboard entry).
// - Records issue, follows miss (negative) and completion (positive) feedback, accumulates completed thread mask.
// - Emits exactly one release to the scoreboard when all issued PAM threads are done.
// - Flags protocol violations.
// PARAMETERS
// NUM_WARPS  8  warps tracked; warp ID width = $clog2(NUM_WARPS)
// NUM_SCB    4  scoreboard entries per warp; scb ID width = $clog2(NUM_SCB)
// NUM_LANES  8  threads per warp; width of PAM and mask ports
// PORTS
// clk               in   1   clock
// rst               in   1   reset, synchronous, active-high
// issue_valid_i     in   1   mem instr handed to MEM unit this cycle
// issue_warpID_i    in   3   warp of issued instr
// issue_scbID_i     in   2   scoreboard entry of issued instr
// issue_PAM_i       in   8   active thread mask of issued instr
// neg_fb_valid_i    in   1   MEM negative feedback (miss parked in MSHR)
// neg_fb_warpID_i   in   3   warp of neg feedback
// neg_fb_scbID_i    in   2   entry of neg feedback
// pos_fb_valid_i    in   1   MEM positive feedback (threads completed)
// pos_fb_warpID_i   in   3   warp of pos feedback
// pos_fb_scbID_i    in   2   entry of pos feedback
// pos_fb_mask_i     in   8   threads completed by this feedback
// release_valid_o   out  1   entry fully complete; scoreboard frees it
// release_warpID_o  out  3   warp of released entry
// release_scbID_o   out  2   entry released
// miss_pending_o    out  8   per warp: >=1 entry in MISS_WAIT
// outstanding_o     out  24  per warp 3-bit count of non-IDLE entries (warp w at [3w+2:3w])
// err_o             out  1   sticky protocol-violation flag
// BEHAVIOUR
// - rst: all entries IDLE, done masks 0. release_valid_o=0, release_warpID_o=0, release_scbID_o=0,
//   miss_pending_o=0, outstanding_o=0, err_o=0. Reset mid-operation discards all tracking; no release emitted.
// - Entry FSM, per (warp, scb):
//   - IDLE --issue--> PEND: store PAM, clear done mask.
//   - PEND --neg--> MISS_WAIT.
//   - PEND/MISS_WAIT --pos--> done |= mask.
//   - (done|mask)==PAM --> IDLE, release.
// - Release registered: release_* valid the cycle after the completing pos_fb. Entry is IDLE from that same
//   edge; a new issue to it is legal in the release cycle.
// - PAM==0 on issue: no state change; release_valid_o pulses next cycle. This replaces a pos-driven release;
//   issue_PAM==0 and a completing pos_fb in the same cycle is a violation: err_o=1, pos release wins.
// - At most one pos_fb per cycle, so at most one release per cycle.
// - Same cycle, same entry, neg+pos: neg applied first, then pos. If the mask completes -> IDLE + release;
//   otherwise MISS_WAIT.
// - Same cycle, issue and fb to different entries: independent. Issue and fb to the same IDLE entry:
//   issue taken, fb is a violation.
// - err_o set (sticky until rst) and offending event dropped when:
//   - issue to non-IDLE entry;
//   - neg/pos to IDLE entry;
//   - neg to MISS_WAIT entry;
//   - pos_fb_mask_i has bits outside PAM or overlapping done.
// - miss_pending_o and outstanding_o are registered; they reflect entry state after the edge.
//   outstanding_o counts 0..NUM_SCB, no wrap.
// STRUCTURE
// - gpu_mem_pkg: entry state encoding (IDLE=2'd0, PEND=2'd1, MISS_WAIT=2'd2); NUM_WARPS/NUM_SCB/NUM_LANES
//   defaults; ID widths.
// - Sub-module mem_fb_entry: one FSM plus PAM/done registers; per-cycle hit strobes in; complete/err/state out.
//   Instantiated NUM_WARPS*NUM_SCB times by generate.
// - Top: ID decode to one-hot strobes; OR-reduce complete into the release register (one-hot by construction);
//   per-warp miss reduction and popcount.
// TESTING
// - Issue w3/s1 PAM=8'hFF; pos mask=8'h0F, then pos mask=8'hF0 -> release_valid_o=1 one cycle after 2nd fb,
//   warpID=3, scbID=1; outstanding[w3]=0.
// - Issue w0/s2 PAM=8'h81; neg -> miss_pending_o=8'h01; pos mask=8'h81 -> release next cycle;
//   miss_pending_o=8'h00.
// - Same cycle neg+pos to w5/s0 (PAM=8'h03, mask=8'h03) -> release next cycle, miss_pending_o[5] never 1,
//   err_o=0.
// - Issue w2/s3 PAM=8'h00 -> release_valid_o=1 next cycle, warpID=2, scbID=3; no entry state change.
// - Pos to idle w7/s0 -> err_o=1 and stays 1; no release. Issue to busy entry -> err_o=1; original PAM kept.
// - Fill all 4 entries of w1, rst=1 for one cycle -> all outputs 0; a subsequent pos to w1/s0 sets err_o.

Source files
------------

// File: rtl/gpu_mem_pkg.sv
// Shared sizing and entry-state encoding for the memory feedback tracker.
// Contents: lane/warp/scoreboard counts, derived ID and counter widths,
//           per-entry FSM state enum.
package gpu_mem_pkg;

    localparam int unsigned NUM_WARPS = 8;
    localparam int unsigned NUM_SCB   = 4;
    localparam int unsigned NUM_LANES = 8;

    localparam int unsigned WARP_W  = $clog2(NUM_WARPS);
    localparam int unsigned SCB_W   = $clog2(NUM_SCB);
    localparam int unsigned CNT_W   = $clog2(NUM_SCB + 1);
    localparam int unsigned NUM_ENT = NUM_WARPS * NUM_SCB;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PEND      = 2'd1,
        ST_MISS_WAIT = 2'd2
    } entry_state_e;

endpackage

// File: rtl/mem_fb_entry.sv
// Tracks one in-flight memory instruction for a single (warp, scoreboard entry).
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   issue_hit          issue addressed to this entry this cycle
//   neg_hit, pos_hit   negative / positive feedback addressed to this entry
//   issue_pam          active-thread mask of the issued instruction
//   pos_mask           threads completed by the positive feedback
//   state_next_c       state this entry takes at the coming edge
//   complete_c         positive feedback finishes all PAM threads this cycle
//   zero_rel_c         accepted issue carried an empty PAM (release without tracking)
//   err_c              an event addressed to this entry violates the protocol
module mem_fb_entry
    import gpu_mem_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_hit,
    input  logic                 neg_hit,
    input  logic                 pos_hit,
    input  logic [NUM_LANES-1:0] issue_pam,
    input  logic [NUM_LANES-1:0] pos_mask,
    output entry_state_e         state_next_c,
    output logic                 complete_c,
    output logic                 zero_rel_c,
    output logic                 err_c
);

    entry_state_e         state;
    logic [NUM_LANES-1:0] pam;
    logic [NUM_LANES-1:0] done;
    logic [NUM_LANES-1:0] pam_next;
    logic [NUM_LANES-1:0] done_next;
    logic [NUM_LANES-1:0] merged;

    // Next-state: within one cycle neg is applied before pos, so a
    // completing pos overrides the MISS_WAIT transition.
    always_comb begin
        state_next_c = state;
        pam_next     = pam;
        done_next    = done;
        complete_c   = 1'b0;
        zero_rel_c   = 1'b0;
        err_c        = 1'b0;
        merged       = done | pos_mask;

        case (state)
            ST_IDLE: begin
                if (issue_hit) begin
                    if (issue_pam == '0) begin
                        zero_rel_c = 1'b1;
                    end else begin
                        state_next_c = ST_PEND;
                        pam_next     = issue_pam;
                        done_next    = '0;
                    end
                end
                if (neg_hit || pos_hit) begin
                    err_c = 1'b1;
                end
            end
            ST_PEND, ST_MISS_WAIT: begin
                if (issue_hit) begin
                    err_c = 1'b1;
                end
                if (neg_hit) begin
                    if (state == ST_MISS_WAIT) begin
                        err_c = 1'b1;
                    end else begin
                        state_next_c = ST_MISS_WAIT;
                    end
                end
                if (pos_hit) begin
                    if (((pos_mask & ~pam) != '0) || ((pos_mask & done) != '0)) begin
                        err_c = 1'b1;
                    end else if (merged == pam) begin
                        state_next_c = ST_IDLE;
                        done_next    = '0;
                        complete_c   = 1'b1;
                    end else begin
                        done_next = merged;
                    end
                end
            end
            default: begin
                state_next_c = ST_IDLE;
            end
        endcase
    end

    // State, PAM and done-mask registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            pam   <= '0;
            done  <= '0;
        end else begin
            state <= state_next_c;
            pam   <= pam_next;
            done  <= done_next;
        end
    end

endmodule

// File: rtl/mem_fb_tracker.sv
// Receives MEM-unit feedback for in-flight LW/SW instructions and emits one
// registered release per completed (warp, scoreboard entry).
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   issue_*                          instruction handed to the MEM unit
//   neg_fb_*                         miss parked in the MSHR
//   pos_fb_*                         threads completed
//   release_valid_o/warpID_o/scbID_o entry fully complete (registered)
//   miss_pending_o                   per warp, any entry in MISS_WAIT
//   outstanding_o                    per warp count of non-IDLE entries
//   err_o                            sticky protocol-violation flag
module mem_fb_tracker
    import gpu_mem_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         issue_valid_i,
    input  logic [WARP_W-1:0]            issue_warpID_i,
    input  logic [SCB_W-1:0]             issue_scbID_i,
    input  logic [NUM_LANES-1:0]         issue_PAM_i,
    input  logic                         neg_fb_valid_i,
    input  logic [WARP_W-1:0]            neg_fb_warpID_i,
    input  logic [SCB_W-1:0]             neg_fb_scbID_i,
    input  logic                         pos_fb_valid_i,
    input  logic [WARP_W-1:0]            pos_fb_warpID_i,
    input  logic [SCB_W-1:0]             pos_fb_scbID_i,
    input  logic [NUM_LANES-1:0]         pos_fb_mask_i,
    output logic                         release_valid_o,
    output logic [WARP_W-1:0]            release_warpID_o,
    output logic [SCB_W-1:0]             release_scbID_o,
    output logic [NUM_WARPS-1:0]         miss_pending_o,
    output logic [NUM_WARPS*CNT_W-1:0]   outstanding_o,
    output logic                         err_o
);

    logic [NUM_ENT-1:0] issue_hit;
    logic [NUM_ENT-1:0] neg_hit;
    logic [NUM_ENT-1:0] pos_hit;
    logic [NUM_ENT-1:0] complete_c;
    logic [NUM_ENT-1:0] zero_rel_c;
    logic [NUM_ENT-1:0] ent_err_c;
    entry_state_e       st_next [NUM_ENT];

    // Entry index g maps to warp g/NUM_SCB, scoreboard entry g%NUM_SCB.
    for (genvar g = 0; g < NUM_ENT; g++) begin : g_ent
        assign issue_hit[g] = issue_valid_i
                              && (issue_warpID_i == WARP_W'(g / NUM_SCB))
                              && (issue_scbID_i  == SCB_W'(g % NUM_SCB));
        assign neg_hit[g]   = neg_fb_valid_i
                              && (neg_fb_warpID_i == WARP_W'(g / NUM_SCB))
                              && (neg_fb_scbID_i  == SCB_W'(g % NUM_SCB));
        assign pos_hit[g]   = pos_fb_valid_i
                              && (pos_fb_warpID_i == WARP_W'(g / NUM_SCB))
                              && (pos_fb_scbID_i  == SCB_W'(g % NUM_SCB));

        mem_fb_entry u_entry (
            .clk          (clk),
            .rst          (rst),
            .issue_hit    (issue_hit[g]),
            .neg_hit      (neg_hit[g]),
            .pos_hit      (pos_hit[g]),
            .issue_pam    (issue_PAM_i),
            .pos_mask     (pos_fb_mask_i),
            .state_next_c (st_next[g]),
            .complete_c   (complete_c[g]),
            .zero_rel_c   (zero_rel_c[g]),
            .err_c        (ent_err_c[g])
        );
    end

    logic                       pos_rel_c;
    logic                       zero_any_c;
    logic [WARP_W-1:0]          pos_warp_c;
    logic [SCB_W-1:0]           pos_scb_c;
    logic [WARP_W-1:0]          zero_warp_c;
    logic [SCB_W-1:0]           zero_scb_c;
    logic                       err_next_c;
    logic [NUM_WARPS-1:0]       miss_next_c;
    logic [NUM_WARPS*CNT_W-1:0] outst_next_c;

    // Release IDs are OR-reduced: at most one pos_fb per cycle and at most
    // one issue per cycle keep each source one-hot.
    always_comb begin
        pos_warp_c  = '0;
        pos_scb_c   = '0;
        zero_warp_c = '0;
        zero_scb_c  = '0;
        for (int unsigned i = 0; i < NUM_ENT; i++) begin
            if (complete_c[i]) begin
                pos_warp_c = pos_warp_c | WARP_W'(i / NUM_SCB);
                pos_scb_c  = pos_scb_c  | SCB_W'(i % NUM_SCB);
            end
            if (zero_rel_c[i]) begin
                zero_warp_c = zero_warp_c | WARP_W'(i / NUM_SCB);
                zero_scb_c  = zero_scb_c  | SCB_W'(i % NUM_SCB);
            end
        end
        pos_rel_c  = |complete_c;
        zero_any_c = |zero_rel_c;
        // An empty-PAM release colliding with a pos release is itself a violation.
        err_next_c = err_o | (|ent_err_c) | (pos_rel_c & zero_any_c);
    end

    // Per-warp miss flag and occupancy count from post-edge entry state.
    always_comb begin
        miss_next_c  = '0;
        outst_next_c = '0;
        for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            for (int unsigned s = 0; s < NUM_SCB; s++) begin
                if (st_next[w*NUM_SCB + s] == ST_MISS_WAIT) begin
                    miss_next_c[w] = 1'b1;
                end
                if (st_next[w*NUM_SCB + s] != ST_IDLE) begin
                    outst_next_c[w*CNT_W +: CNT_W] = outst_next_c[w*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end

    // Output registers; a pos-driven release takes priority over an empty-PAM one.
    always_ff @(posedge clk) begin
        if (rst) begin
            release_valid_o  <= 1'b0;
            release_warpID_o <= '0;
            release_scbID_o  <= '0;
            miss_pending_o   <= '0;
            outstanding_o    <= '0;
            err_o            <= 1'b0;
        end else begin
            release_valid_o  <= pos_rel_c | zero_any_c;
            release_warpID_o <= pos_rel_c ? pos_warp_c : zero_warp_c;
            release_scbID_o  <= pos_rel_c ? pos_scb_c  : zero_scb_c;
            miss_pending_o   <= miss_next_c;
            outstanding_o    <= outst_next_c;
            err_o            <= err_next_c;
        end
    end

endmodule

// File: tb/tb_mem_fb_tracker.sv
// Directed self-checking bench for mem_fb_tracker.
module tb_mem_fb_tracker;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid_i;
    logic [2:0]  issue_warpID_i;
    logic [1:0]  issue_scbID_i;
    logic [7:0]  issue_PAM_i;
    logic        neg_fb_valid_i;
    logic [2:0]  neg_fb_warpID_i;
    logic [1:0]  neg_fb_scbID_i;
    logic        pos_fb_valid_i;
    logic [2:0]  pos_fb_warpID_i;
    logic [1:0]  pos_fb_scbID_i;
    logic [7:0]  pos_fb_mask_i;
    logic        release_valid_o;
    logic [2:0]  release_warpID_o;
    logic [1:0]  release_scbID_o;
    logic [7:0]  miss_pending_o;
    logic [23:0] outstanding_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_fb_tracker dut (
        .clk              (clk),
        .rst              (rst),
        .issue_valid_i    (issue_valid_i),
        .issue_warpID_i   (issue_warpID_i),
        .issue_scbID_i    (issue_scbID_i),
        .issue_PAM_i      (issue_PAM_i),
        .neg_fb_valid_i   (neg_fb_valid_i),
        .neg_fb_warpID_i  (neg_fb_warpID_i),
        .neg_fb_scbID_i   (neg_fb_scbID_i),
        .pos_fb_valid_i   (pos_fb_valid_i),
        .pos_fb_warpID_i  (pos_fb_warpID_i),
        .pos_fb_scbID_i   (pos_fb_scbID_i),
        .pos_fb_mask_i    (pos_fb_mask_i),
        .release_valid_o  (release_valid_o),
        .release_warpID_o (release_warpID_o),
        .release_scbID_o  (release_scbID_o),
        .miss_pending_o   (miss_pending_o),
        .outstanding_o    (outstanding_o),
        .err_o            (err_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        issue_valid_i   = 1'b0;
        issue_warpID_i  = '0;
        issue_scbID_i   = '0;
        issue_PAM_i     = '0;
        neg_fb_valid_i  = 1'b0;
        neg_fb_warpID_i = '0;
        neg_fb_scbID_i  = '0;
        pos_fb_valid_i  = 1'b0;
        pos_fb_warpID_i = '0;
        pos_fb_scbID_i  = '0;
        pos_fb_mask_i   = '0;
    endtask

    // Apply the staged inputs across one rising edge, then sample at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
    endtask

    task automatic set_issue(input logic [2:0] w, input logic [1:0] s, input logic [7:0] pam);
        issue_valid_i  = 1'b1;
        issue_warpID_i = w;
        issue_scbID_i  = s;
        issue_PAM_i    = pam;
    endtask

    task automatic set_neg(input logic [2:0] w, input logic [1:0] s);
        neg_fb_valid_i  = 1'b1;
        neg_fb_warpID_i = w;
        neg_fb_scbID_i  = s;
    endtask

    task automatic set_pos(input logic [2:0] w, input logic [1:0] s, input logic [7:0] m);
        pos_fb_valid_i  = 1'b1;
        pos_fb_warpID_i = w;
        pos_fb_scbID_i  = s;
        pos_fb_mask_i   = m;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
    endtask

    task automatic check_release(input string tag, input logic [2:0] w, input logic [1:0] s);
        check({tag, "_rv"}, 32'(release_valid_o), 32'd1);
        check({tag, "_rw"}, 32'(release_warpID_o), 32'(w));
        check({tag, "_rs"}, 32'(release_scbID_o), 32'(s));
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        do_reset();
        check("rst_rv",   32'(release_valid_o), 32'd0);
        check("rst_miss", 32'(miss_pending_o), 32'd0);
        check("rst_outs", 32'(outstanding_o), 32'd0);
        check("rst_err",  32'(err_o), 32'd0);

        // Two partial completions of a full-warp instruction.
        set_issue(3'd3, 2'd1, 8'hFF); step();
        check("t1_outs_busy", 32'(outstanding_o[9 +: 3]), 32'd1);
        set_pos(3'd3, 2'd1, 8'h0F); step();
        check("t1_no_rel", 32'(release_valid_o), 32'd0);
        set_pos(3'd3, 2'd1, 8'hF0); step();
        check_release("t1", 3'd3, 2'd1);
        check("t1_outs_idle", 32'(outstanding_o[9 +: 3]), 32'd0);
        step();
        check("t1_rel_pulse", 32'(release_valid_o), 32'd0);

        // Miss then completion.
        set_issue(3'd0, 2'd2, 8'h81); step();
        set_neg(3'd0, 2'd2); step();
        check("t2_miss", 32'(miss_pending_o), 32'h01);
        set_pos(3'd0, 2'd2, 8'h81); step();
        check_release("t2", 3'd0, 2'd2);
        check("t2_miss_clr", 32'(miss_pending_o), 32'h00);

        // Same-cycle neg+pos that completes the entry.
        set_issue(3'd5, 2'd0, 8'h03); step();
        set_neg(3'd5, 2'd0);
        set_pos(3'd5, 2'd0, 8'h03); step();
        check_release("t3", 3'd5, 2'd0);
        check("t3_miss", 32'(miss_pending_o), 32'h00);
        check("t3_err", 32'(err_o), 32'd0);

        // Empty PAM releases immediately without occupying the entry.
        set_issue(3'd2, 2'd3, 8'h00); step();
        check_release("t4", 3'd2, 2'd3);
        check("t4_outs", 32'(outstanding_o), 32'd0);
        check("t4_err", 32'(err_o), 32'd0);

        // Pos to an idle entry is flagged and sticky.
        set_pos(3'd7, 2'd0, 8'h01); step();
        check("t5_err", 32'(err_o), 32'd1);
        check("t5_no_rel", 32'(release_valid_o), 32'd0);
        step();
        check("t5_err_sticky", 32'(err_o), 32'd1);

        // Issue to a busy entry is flagged; original PAM still governs completion.
        do_reset();
        check("t6_err_clr", 32'(err_o), 32'd0);
        set_issue(3'd4, 2'd1, 8'h0F); step();
        set_issue(3'd4, 2'd1, 8'hFF); step();
        check("t6_err", 32'(err_o), 32'd1);
        check("t6_outs", 32'(outstanding_o[12 +: 3]), 32'd1);
        set_pos(3'd4, 2'd1, 8'h0F); step();
        check_release("t6", 3'd4, 2'd1);

        // Empty-PAM issue colliding with a completing pos: pos release wins, error raised.
        do_reset();
        set_issue(3'd6, 2'd0, 8'h01); step();
        set_pos(3'd6, 2'd0, 8'h01);
        set_issue(3'd6, 2'd1, 8'h00); step();
        check_release("t7", 3'd6, 2'd0);
        check("t7_err", 32'(err_o), 32'd1);

        // Fill warp 1, then reset discards all tracking.
        do_reset();
        for (int s = 0; s < 4; s++) begin
            set_issue(3'd1, 2'(s), 8'h01); step();
        end
        check("t8_outs_full", 32'(outstanding_o), 32'h20);
        do_reset();
        check("t8_rst_rv",   32'(release_valid_o), 32'd0);
        check("t8_rst_outs", 32'(outstanding_o), 32'd0);
        check("t8_rst_miss", 32'(miss_pending_o), 32'd0);
        check("t8_rst_err",  32'(err_o), 32'd0);
        set_pos(3'd1, 2'd0, 8'h01); step();
        check("t8_err", 32'(err_o), 32'd1);
        check("t8_no_rel", 32'(release_valid_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
